icache_refill_axi: RTL and testbench

//  AXI4 read master that services instruction-cache line refills. Sits between the icache miss handler and the AXI

---
 rtl/icache_refill_axi.sv | 75 +++++++
 tb/tb_icache_refill_axi.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/icache_refill_axi.sv
// icache_refill_axi: AXI4 read master that fetches one instruction-cache line per request
// and presents the whole line with a single-cycle gnt pulse.
module icache_refill_axi #(
    parameter int LINE_WORDS = 8,
    parameter int ID_W = 4,
    parameter logic [ID_W-1:0] AR_ID = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic [31:0]                addr,
    output logic                       gnt,
    output logic [LINE_WORDS-1:0][31:0] data,
    output logic                       err,
    output logic [ID_W-1:0]            arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready
);
    localparam int BW = $clog2(LINE_WORDS + 1);
    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] addr_q;
    logic [BW-1:0] beat;
    logic err_q;
    logic beat_hs;
    assign arid = AR_ID;
    assign araddr = addr_q;
    assign arlen = 8'(LINE_WORDS - 1);
    assign arsize = 3'b010;
    assign arburst = 2'b01;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        arvalid = state == AR;
        rready = state == R;
        gnt = state == DONE;
        err = gnt && err_q;
        beat_hs = rvalid && rready;
        state_nx = state;
        case (state)
            IDLE: state_nx = rd_req ? AR : IDLE;
            AR:   state_nx = arready ? R : AR;
            R:    state_nx = beat_hs && rlast ? DONE : R;
            DONE: state_nx = IDLE;
        endcase
    end
    // A burst that ends before the line is full leaves stale words, so it is reported as an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            beat <= '0;
            err_q <= 1'b0;
            data <= '0;
        end else if (state == IDLE && rd_req) begin
            addr_q <= addr & 32'hFFFF_FFE0;
            beat <= '0;
            err_q <= 1'b0;
        end else if (beat_hs) begin
            for (int i = 0; i < LINE_WORDS; i++)
                if (beat == BW'(i)) data[i] <= rdata;
            beat <= beat == BW'(LINE_WORDS) ? beat : beat + 1'b1;
            err_q <= err_q || rresp != 2'b00 || (rlast && beat < BW'(LINE_WORDS - 1));
        end
    end
endmodule

// File: tb/tb_icache_refill_axi.sv
// tb_icache_refill_axi: randomized refill bursts checked against a line-buffer model.
module tb_icache_refill_axi;
    logic clk = 1'b0, rst, rd_req, arready, rlast, rvalid, gnt, err, arvalid, rready;
    logic [31:0] addr, araddr, rdata;
    logic [7:0][31:0] data, mdl;
    logic [3:0] arid;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst, rresp;
    int n_chk = 0, n_fail = 0, lat;

    always #5 clk = ~clk;

    icache_refill_axi dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .addr(addr), .gnt(gnt), .data(data), .err(err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One refill: the model line keeps old words unless a beat below 8 overwrites them.
    task automatic burst(input logic [31:0] a, input int ar_wait, input int n, input int gmin,
                         input int gmax, input int err_beat, input int err_pct,
                         input bit hold, input bit started, input bit seq);
        logic [31:0] exp_a = a & 32'hFFFF_FFE0;
        logic exp_err = n < 8;
        lat = 1;
        if (!started) begin
            rd_req = 1'b1;
            addr = a;
            check("idle_arvalid", arvalid, 0);
            check("idle_gnt", gnt, 0);
            @(negedge clk); lat++;
            rd_req = hold;
            addr = hold ? a : $urandom;
        end
        for (int w = 0; w < ar_wait; w++) begin
            arready = 1'b0;
            rvalid = 1'($urandom_range(1));
            check("ar_wait_arvalid", arvalid, 1);
            check("ar_wait_araddr", araddr, exp_a);
            check("ar_wait_rready", rready, 0);
            @(negedge clk); lat++;
        end
        arready = 1'b1;
        rvalid = 1'b0;
        check("ar_arvalid", arvalid, 1);
        check("ar_araddr", araddr, exp_a);
        check("ar_arlen", arlen, 7);
        check("ar_arsize", arsize, 2);
        check("ar_arburst", arburst, 1);
        check("ar_arid", arid, 0);
        @(negedge clk); lat++;
        for (int b = 0; b < n; b++) begin
            int g = $urandom_range(gmax, gmin);
            for (int k = 0; k < g; k++) begin
                rvalid = 1'b0;
                arready = 1'($urandom_range(1));
                rdata = $urandom;
                check("gap_rready", rready, 1);
                check("gap_gnt", gnt, 0);
                @(negedge clk); lat++;
            end
            rvalid = 1'b1;
            rdata = seq ? 32'hA0 + b : $urandom;
            rresp = (b == err_beat || $urandom_range(99) < err_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
            rlast = b == n - 1;
            check("beat_rready", rready, 1);
            check("beat_arvalid", arvalid, 0);
            if (b < 8) mdl[b] = rdata;
            if (rresp != 2'b00) exp_err = 1'b1;
            @(negedge clk); lat++;
        end
        rvalid = 1'($urandom_range(1));
        rlast = 1'b0;
        rresp = 2'b00;
        rdata = $urandom;
        check("done_gnt", gnt, 1);
        check("done_err", err, exp_err);
        check("done_data", data, mdl);
        check("done_rready", rready, 0);
        @(negedge clk);
        rvalid = 1'b0;
        check("after_gnt", gnt, 0);
        check("after_err", err, 0);
        check("after_data", data, mdl);
        if (hold) begin
            check("hold_idle_arvalid", arvalid, 0);
            @(negedge clk);
            check("hold_reissue_arvalid", arvalid, 1);
            check("hold_reissue_araddr", araddr, exp_a);
            rd_req = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; rd_req = 1'b0; addr = '0; arready = 1'b0; rvalid = 1'b0;
        rlast = 1'b0; rdata = '0; rresp = 2'b00; mdl = '0;
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_araddr", araddr, 0);
        check("rst_data", data, 0);
        rst = 1'b0;
        @(negedge clk);
        burst(32'h1FC0_0024, 0, 8, 0, 0, -1, 0, 0, 0, 1);
        check("case1_latency", lat, 11);
        burst($urandom, 5, 8, 0, 0, -1, 0, 0, 0, 0);
        check("case2_latency", lat, 16);
        burst($urandom, 0, 8, 2, 2, 3, 0, 0, 0, 0);
        a = $urandom;
        burst(a, 0, 8, 0, 0, -1, 0, 1, 0, 0);
        burst(a, 0, 8, 0, 1, -1, 0, 0, 1, 0);
        rd_req = 1'b1; addr = $urandom;
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rvalid = 1'b1; rdata = $urandom; rlast = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        mdl = '0;
        check("midrst_rready", rready, 0);
        check("midrst_arvalid", arvalid, 0);
        check("midrst_gnt", gnt, 0);
        check("midrst_data", data, mdl);
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b0;
        check("postrst_gnt", gnt, 0);
        check("postrst_arvalid", arvalid, 0);
        burst(32'h1FC0_0024, 0, 8, 0, 0, -1, 0, 0, 0, 1);
        check("postrst_latency", lat, 11);
        burst($urandom, 0, 5, 0, 0, -1, 0, 0, 0, 0);
        for (int t = 0; t < 25; t++)
            burst($urandom, $urandom_range(3), $urandom_range(99) < 20 ? $urandom_range(10, 1) : 8,
                  0, $urandom_range(2), -1, 5, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
